sha256_id_buf: RTL and testbench

SHA256_ID_BUF -- requirements
Module: sha256_id_buf

---
 rtl/sha256_id_buf_pkg.sv | 16 +
 rtl/sha256_id_fifo.sv | 48 ++++
 rtl/sha256_id_buf.sv | 67 ++++++
 tb/tb_sha256_id_buf.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_id_buf_pkg.sv
// Shared parameters, entry payload type and elaboration helpers for the SHA-256 ID buffer.
package sha256_id_buf_pkg;

   localparam int unsigned ID_W_DEF  = 6;
   localparam int unsigned DEPTH_DEF = 8;

   typedef struct packed {
      logic [ID_W_DEF-1:0] id;
      logic                last;
   } id_entry_t;

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/sha256_id_fifo.sv
// Storage and pointer bookkeeping for the ID buffer: extra-MSB pointers, unreset data array.
module sha256_id_fifo
   import sha256_id_buf_pkg::*;
#(
   parameter int unsigned W     = $bits(id_entry_t),
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Pointers wrap modulo 2*DEPTH so full and empty stay distinguishable.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/sha256_id_buf.sv
// In-order ID buffer with enable/sync-clear gating and a status register of the last popped ID.
module sha256_id_buf
   import sha256_id_buf_pkg::*;
#(
   parameter int unsigned ID_W  = ID_W_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            en,
   input  logic            sync_rst,
   input  logic [ID_W-1:0] id_in,
   input  logic            id_in_last,
   input  logic            id_in_valid,
   output logic            id_in_ready,
   output logic [ID_W-1:0] id_out,
   output logic            id_out_last,
   output logic            id_out_valid,
   input  logic            id_out_ready,
   output logic [ID_W-1:0] status_id
);

   localparam int unsigned ENT_W = ID_W + 1;

   if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
      $error("sha256_id_buf: DEPTH must be a power of two and at least 2");
   end

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [ENT_W-1:0] wr_ent;
   logic [ENT_W-1:0] rd_ent;

   // Handshakes are qualified by enable and blocked during a synchronous clear.
   assign id_in_ready  = en & ~full  & ~sync_rst;
   assign id_out_valid = en & ~empty & ~sync_rst;
   assign push         = id_in_valid  & id_in_ready;
   assign pop          = id_out_valid & id_out_ready;

   assign wr_ent      = {id_in, id_in_last};
   assign id_out      = rd_ent[ENT_W-1:1];
   assign id_out_last = rd_ent[0];

   sha256_id_fifo #(
      .W     (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .nrst  (nrst),
      .clr   (sync_rst),
      .push  (push),
      .pop   (pop),
      .wdata (wr_ent),
      .rdata (rd_ent),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)         status_id <= '0;
      else if (sync_rst) status_id <= '0;
      else if (pop)      status_id <= id_out;
   end

endmodule

// File: tb/tb_sha256_id_buf.sv
// Self-checking bench for sha256_id_buf: vector table, directed corner sequences and random traffic vs a queue model.
module tb_sha256_id_buf;
   import sha256_id_buf_pkg::*;

   localparam int unsigned ID_W  = ID_W_DEF;
   localparam int unsigned DEPTH = DEPTH_DEF;

   logic            clk = 1'b0;
   logic            nrst;
   logic            en;
   logic            sync_rst;
   logic [ID_W-1:0] id_in;
   logic            id_in_last;
   logic            id_in_valid;
   logic            id_in_ready;
   logic [ID_W-1:0] id_out;
   logic            id_out_last;
   logic            id_out_valid;
   logic            id_out_ready;
   logic [ID_W-1:0] status_id;

   sha256_id_buf #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .nrst         (nrst),
      .en           (en),
      .sync_rst     (sync_rst),
      .id_in        (id_in),
      .id_in_last   (id_in_last),
      .id_in_valid  (id_in_valid),
      .id_in_ready  (id_in_ready),
      .id_out       (id_out),
      .id_out_last  (id_out_last),
      .id_out_valid (id_out_valid),
      .id_out_ready (id_out_ready),
      .status_id    (status_id)
   );

   always #5 clk = ~clk;

   int unsigned chk_cnt  = 0;
   int unsigned pass_cnt = 0;

   // Reference model: queue contents plus last popped ID.
   id_entry_t       q[$];
   logic [ID_W-1:0] mstatus;
   id_entry_t       sent[$];
   id_entry_t       seen[$];

   typedef struct {
      logic            v;
      logic [ID_W-1:0] id;
      logic            last;
      logic            rdy;
      logic            e_ready;
      logic            e_valid;
      logic [ID_W-1:0] e_id;
      logic            e_last;
      logic [ID_W-1:0] e_status;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic bit m_ready();
      return en && !sync_rst && (q.size() < DEPTH);
   endfunction

   function automatic bit m_valid();
      return en && !sync_rst && (q.size() > 0);
   endfunction

   task automatic drive(input bit e, input bit sr, input bit v, input logic [ID_W-1:0] id,
                        input bit l, input bit r);
      en = e; sync_rst = sr; id_in_valid = v; id_in = id; id_in_last = l; id_out_ready = r;
   endtask

   // Called at the negedge: compare DUT against model, then apply the coming edge to the model.
   task automatic check_and_advance(input string tag);
      bit er, ev;
      er = m_ready();
      ev = m_valid();
      chk({tag, "_ready"},  32'(id_in_ready),  32'(er));
      chk({tag, "_valid"},  32'(id_out_valid), 32'(ev));
      if (ev) begin
         chk({tag, "_id"},   32'(id_out),      32'(q[0].id));
         chk({tag, "_last"}, 32'(id_out_last), 32'(q[0].last));
      end
      chk({tag, "_status"}, 32'(status_id), 32'(mstatus));
      if (sync_rst) begin
         q.delete();
         mstatus = '0;
      end else begin
         if (ev && id_out_ready) begin
            seen.push_back('{id: id_out, last: id_out_last});
            mstatus = q[0].id;
            void'(q.pop_front());
         end
         if (er && id_in_valid) begin
            q.push_back('{id: id_in, last: id_in_last});
            sent.push_back('{id: id_in, last: id_in_last});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input string tag);
      @(negedge clk);
      check_and_advance(tag);
   endtask

   task automatic drain(input string tag);
      id_in_valid  = 1'b0;
      id_out_ready = 1'b1;
      for (int c = 0; c < 40 && q.size() > 0; c++) cycle(tag);
      chk({tag, "_drained"}, 32'(q.size()), 32'd0);
      @(negedge clk);
      chk({tag, "_empty"}, 32'(id_out_valid), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic fill_test(input string tag);
      int unsigned nxt;
      bit          acc;
      seen.delete();
      nxt = 1;
      for (int c = 0; c < 11; c++) begin
         drive(1, 0, 1, ID_W'(nxt), nxt[0], 0);
         acc = m_ready();
         cycle(tag);
         if (acc && nxt < 9) nxt++;
      end
      chk({tag, "_accepted"}, 32'(nxt - 1), 32'd8);
      @(negedge clk);
      chk({tag, "_full_ready"}, 32'(id_in_ready), 32'd0);
      @(posedge clk);
      #1;
      id_out_ready = 1'b1;
      for (int c = 0; c < 20 && !(sent.size() > 0 && sent[$].id == ID_W'(9)); c++) cycle(tag);
      drain(tag);
      chk({tag, "_count"}, 32'(seen.size()), 32'd9);
      for (int i = 0; i < seen.size() && i < 9; i++)
         chk({tag, "_order"}, 32'(seen[i].id), 32'(i + 1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t        vt[4];
      int unsigned issued;
      int unsigned gap;
      int unsigned stall;
      bit          last_acc;
      int unsigned bad;

      nrst = 1'b0;
      drive(0, 0, 0, '0, 0, 0);
      q.delete();
      mstatus = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid",  32'(id_out_valid), 32'd0);
      chk("rst_ready",  32'(id_in_ready),  32'd0);
      chk("rst_status", 32'(status_id),    32'd0);
      nrst = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(id_in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Pass-through: 0x05/0 then 0x06/1 with output always ready.
      vt[0] = '{1, 6'h05, 0, 1, 1, 0, 6'h00, 0, 6'h00};
      vt[1] = '{1, 6'h06, 1, 1, 1, 1, 6'h05, 0, 6'h00};
      vt[2] = '{0, 6'h00, 0, 1, 1, 1, 6'h06, 1, 6'h05};
      vt[3] = '{0, 6'h00, 0, 1, 1, 0, 6'h00, 0, 6'h06};
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, vt[i].v, vt[i].id, vt[i].last, vt[i].rdy);
         @(negedge clk);
         chk($sformatf("vec%0d_ready", i),  32'(id_in_ready),  32'(vt[i].e_ready));
         chk($sformatf("vec%0d_valid", i),  32'(id_out_valid), 32'(vt[i].e_valid));
         if (vt[i].e_valid) begin
            chk($sformatf("vec%0d_id", i),   32'(id_out),      32'(vt[i].e_id));
            chk($sformatf("vec%0d_last", i), 32'(id_out_last), 32'(vt[i].e_last));
         end
         chk($sformatf("vec%0d_status", i), 32'(status_id), 32'(vt[i].e_status));
         check_and_advance($sformatf("vec%0d_model", i));
      end

      fill_test("fill");

      // Enable freeze with three entries queued.
      seen.delete();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, ID_W'(6'h11 + i), i == 2, 0);
         cycle("en_load");
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 6'h3F, 1, 1);
         cycle("en_off");
      end
      chk("en_off_popped", 32'(seen.size()), 32'd0);
      drive(1, 0, 0, '0, 0, 1);
      drain("en_on");
      chk("en_on_count", 32'(seen.size()), 32'd3);
      for (int i = 0; i < seen.size() && i < 3; i++)
         chk("en_on_order", 32'({seen[i].id, seen[i].last}), 32'({ID_W'(6'h11 + i), i == 2}));

      // Synchronous clear with four entries queued.
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 1, ID_W'(6'h01 + i), 0, 0);
         cycle("srst_load");
      end
      drive(1, 1, 0, '0, 0, 1);
      cycle("srst_pulse");
      drive(1, 0, 0, '0, 0, 1);
      @(negedge clk);
      chk("srst_valid",  32'(id_out_valid), 32'd0);
      chk("srst_status", 32'(status_id),    32'd0);
      check_and_advance("srst_after");
      drive(1, 0, 1, 6'h2A, 1, 1);
      cycle("srst_push");
      drive(1, 0, 0, '0, 0, 1);
      @(negedge clk);
      chk("srst_first_valid", 32'(id_out_valid), 32'd1);
      chk("srst_first_id",    32'(id_out),       32'h2A);
      check_and_advance("srst_pop");
      drain("srst");

      // Hold seven entries while 20 concurrent push/pop cycles carry the pointers across the wrap.
      seen.delete();
      for (int i = 0; i < 7; i++) begin
         drive(1, 0, 1, ID_W'(6'h20 + i), i[0], 0);
         cycle("wrap_load");
      end
      for (int k = 0; k < 20; k++) begin
         drive(1, 0, 1, ID_W'(6'h30 + k), k[0], 1);
         cycle("wrap_run");
      end
      drain("wrap");
      chk("wrap_count", 32'(seen.size()), 32'd27);

      fill_test("fill2");

      // Random gaps and stalls over 100 IDs.
      sent.delete();
      seen.delete();
      issued = 0; gap = 0; stall = 0; last_acc = 0;
      drive(1, 0, 0, '0, 0, 1);
      for (int c = 0; c < 3000 && (issued < 100 || id_in_valid || q.size() > 0); c++) begin
         if (id_in_valid && last_acc) begin
            id_in_valid = 1'b0;
            gap = $urandom_range(0, 3);
         end
         if (!id_in_valid && issued < 100) begin
            if (gap == 0) begin
               id_in_valid = 1'b1;
               id_in       = ID_W'($urandom);
               id_in_last  = 1'($urandom);
               issued++;
            end else gap--;
         end
         if (stall > 0) begin
            id_out_ready = 1'b0;
            stall--;
         end else begin
            id_out_ready = 1'b1;
            if ($urandom_range(0, 1) == 1) stall = $urandom_range(1, 3);
         end
         last_acc = m_ready() && id_in_valid;
         cycle("bp");
      end
      chk("bp_sent", 32'(sent.size()), 32'd100);
      chk("bp_seen", 32'(seen.size()), 32'd100);
      bad = 0;
      for (int i = 0; i < sent.size() && i < seen.size(); i++)
         if (sent[i] !== seen[i]) bad++;
      chk("bp_sequence", 32'(bad), 32'd0);

      // Asynchronous reset with traffic in flight.
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, ID_W'(6'h15 + i), 0, 0);
         cycle("mid_load");
      end
      drive(1, 0, 1, 6'h3C, 0, 1);
      @(negedge clk);
      nrst = 1'b0;
      #1;
      chk("mid_rst_valid",  32'(id_out_valid), 32'd0);
      chk("mid_rst_status", 32'(status_id),    32'd0);
      q.delete();
      mstatus = '0;
      id_in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_hold_valid", 32'(id_out_valid), 32'd0);
      nrst = 1'b1;
      @(posedge clk);
      #1;
      cycle("mid_after");
      drive(1, 0, 1, 6'h07, 1, 1);
      cycle("mid_push");
      drain("mid");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
